// File: rtl/weight_bram_scheduler_if.sv
// Bus bundle between the weight loader / MAC array and the scheduler.
// The slave side is the scheduler; the master side drives commands and load rows.
interface weight_bram_scheduler_if #(
    parameter int DATA_W = 1280,
    parameter int ADDR_W = 12
);
    // load side
    logic              ld_start;
    logic [ADDR_W-1:0] ld_len;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    // read side
    logic              rd_start;
    logic [ADDR_W-1:0] rd_len;
    logic              rd_free;
    logic              rd_next;
    logic              rd_valid;
    logic              rd_done;
    // BRAM port A (write) and port B (read)
    logic              bram_a_en;
    logic              bram_a_wen;
    logic [ADDR_W-1:0] bram_a_addr;
    logic [DATA_W-1:0] bram_a_din;
    logic              bram_b_en;
    logic [ADDR_W-1:0] bram_b_addr;
    // status
    logic [1:0]        bank_full;
    logic              err;

    modport slave (
        input  ld_start, ld_len, ld_valid, ld_data, rd_start, rd_len, rd_free, rd_next,
        output ld_ready, rd_valid, rd_done, bram_a_en, bram_a_wen, bram_a_addr, bram_a_din,
               bram_b_en, bram_b_addr, bank_full, err
    );

    modport master (
        output ld_start, ld_len, ld_valid, ld_data, rd_start, rd_len, rd_free, rd_next,
        input  ld_ready, rd_valid, rd_done, bram_a_en, bram_a_wen, bram_a_addr, bram_a_din,
               bram_b_en, bram_b_addr, bank_full, err
    );
endinterface

// File: rtl/weight_bram_scheduler.sv
// Ping-pong weight BRAM scheduler: a loader fills one bank through port A while
// the MAC array reads the other bank through port B. Address MSB selects the bank.
module weight_bram_scheduler #(
    parameter int DATA_W = 1280,
    parameter int ADDR_W = 12
) (
    input  logic clk,
    input  logic rst,
    weight_bram_scheduler_if.slave bus
);
    localparam int ROW_W = ADDR_W - 1;
    localparam logic [ADDR_W-1:0] MAX_LEN = ADDR_W'(1) << ROW_W;
    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

    typedef enum logic [1:0] {L_IDLE, L_FILL, L_DONE}  lstate_t;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_DRAIN} rstate_t;

    lstate_t           r_lstate;
    rstate_t           r_rstate;
    logic              r_wb;
    logic              r_rb;
    logic [1:0]        r_bank_full;
    logic [ROW_W-1:0]  r_wr_cnt;
    logic [ROW_W-1:0]  r_rd_cnt;
    logic [ADDR_W-1:0] r_ld_len;
    logic [ADDR_W-1:0] r_rd_len;
    logic              r_rd_free;
    logic              r_err;
    logic              r_rd_valid;
    logic              r_rd_done;

    logic              w_ld_len_ok;
    logic              w_rd_len_ok;
    logic              w_ld_go;
    logic              w_rd_go;
    logic              w_ld_bad;
    logic              w_rd_bad;
    logic              w_wr;
    logic              w_wr_last;
    logic              w_rd;
    logic              w_rd_last;
    logic [1:0]        w_bank_full_nxt;
    logic [DATA_W-1:0] w_din;

    // Command acceptance: a command that is not accepted is flagged and dropped.
    assign w_ld_len_ok = (bus.ld_len != '0) && (bus.ld_len <= MAX_LEN);
    assign w_rd_len_ok = (bus.rd_len != '0) && (bus.rd_len <= MAX_LEN);
    assign w_ld_go     = bus.ld_start && (r_lstate == L_IDLE) && !r_bank_full[r_wb] && w_ld_len_ok;
    assign w_rd_go     = bus.rd_start && (r_rstate == R_IDLE) &&  r_bank_full[r_rb] && w_rd_len_ok;
    assign w_ld_bad    = bus.ld_start && !w_ld_go;
    assign w_rd_bad    = bus.rd_start && !w_rd_go;

    // Row transfers; the counters are one bit narrower than the lengths, so
    // compare against len-1 with the counter zero-extended.
    assign w_wr      = (r_lstate == L_FILL) && bus.ld_valid;
    assign w_wr_last = w_wr && ({1'b0, r_wr_cnt} == (r_ld_len - ONE));
    assign w_rd      = (r_rstate == R_READ) && bus.rd_next;
    assign w_rd_last = w_rd && ({1'b0, r_rd_cnt} == (r_rd_len - ONE));

    assign w_din           = bus.ld_data;
    assign bus.ld_ready    = (r_lstate == L_FILL);
    assign bus.bram_a_en   = w_wr;
    assign bus.bram_a_wen  = w_wr;
    assign bus.bram_a_addr = {r_wb, r_wr_cnt};
    assign bus.bram_a_din  = w_din;
    assign bus.bram_b_en   = w_rd;
    assign bus.bram_b_addr = {r_rb, r_rd_cnt};
    assign bus.rd_valid    = r_rd_valid;
    assign bus.rd_done     = r_rd_done;
    assign bus.bank_full   = r_bank_full;
    assign bus.err         = r_err;

    // Bank flags: loader sets its bank, reader releases its bank; both can land together.
    always_comb begin
        w_bank_full_nxt = r_bank_full;
        if (r_lstate == L_DONE)
            w_bank_full_nxt[r_wb] = 1'b1;
        if ((r_rstate == R_DRAIN) && r_rd_free)
            w_bank_full_nxt[r_rb] = 1'b0;
    end

    // Load FSM: accept ld_len rows into the write bank, then hand the bank over.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lstate <= L_IDLE;
            r_wb     <= 1'b0;
            r_wr_cnt <= '0;
            r_ld_len <= '0;
        end else begin
            case (r_lstate)
                L_IDLE: if (w_ld_go) begin
                    r_ld_len <= bus.ld_len;
                    r_wr_cnt <= '0;
                    r_lstate <= L_FILL;
                end
                L_FILL: if (w_wr) begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                    if (w_wr_last)
                        r_lstate <= L_DONE;
                end
                L_DONE: begin
                    r_wb     <= ~r_wb;
                    r_lstate <= L_IDLE;
                end
                default: r_lstate <= L_IDLE;
            endcase
        end
    end

    // Read FSM: issue rd_len rows on demand, then optionally release the bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate   <= R_IDLE;
            r_rb       <= 1'b0;
            r_rd_cnt   <= '0;
            r_rd_len   <= '0;
            r_rd_free  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_done  <= 1'b0;
        end else begin
            r_rd_valid <= w_rd;
            r_rd_done  <= w_rd_last;
            case (r_rstate)
                R_IDLE: if (w_rd_go) begin
                    r_rd_len  <= bus.rd_len;
                    r_rd_free <= bus.rd_free;
                    r_rd_cnt  <= '0;
                    r_rstate  <= R_READ;
                end
                R_READ: if (w_rd) begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                    if (w_rd_last)
                        r_rstate <= R_DRAIN;
                end
                R_DRAIN: begin
                    if (r_rd_free)
                        r_rb <= ~r_rb;
                    r_rstate <= R_IDLE;
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // Status registers: bank flags and the one-cycle error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank_full <= 2'b00;
            r_err       <= 1'b0;
        end else begin
            r_bank_full <= w_bank_full_nxt;
            r_err       <= w_ld_bad | w_rd_bad;
        end
    end
endmodule

// File: doc/weight_bram_scheduler.md
WEIGHT_BRAM_SCHEDULER -- requirements
Module: weight_bram_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 1280, meaning BRAM row width (5*MAC_NUM, MAC_NUM=256).
REQ-002 SHALL have parameter ADDR_W, default 12, meaning BRAM address width. Bank = address MSB; rows per bank = 2^(ADDR_W-1).
REQ-003 SHALL have port clk  in  1  clock.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port ld_start  in  1  pulse that begins a bank load.
REQ-006 SHALL have port ld_len  in  ADDR_W  rows to load (legal 1..2^(ADDR_W-1)).
REQ-007 SHALL have ld_valid in 1, ld_data in DATA_W, and ld_ready out 1, meaning the load-row handshake.
REQ-008 SHALL have port rd_start  in  1  pulse that begins a read pass.
REQ-009 SHALL have port rd_len  in  ADDR_W  rows to read (legal 1..2^(ADDR_W-1)).
REQ-010 SHALL have port rd_free  in  1  sampled with rd_start; 1 = release bank at pass end.
REQ-011 SHALL have port rd_next  in  1  request one row from the MAC array.
REQ-012 SHALL have rd_valid out 1 and rd_done out 1. rd_valid flags bram_b_dout valid. rd_done pulses at pass end.
REQ-013 SHALL have bram_a_en, bram_a_wen, bram_a_addr[ADDR_W-1:0] and bram_a_din[DATA_W-1:0] as outputs, meaning port A (write).
REQ-014 SHALL have bram_b_en out 1 and bram_b_addr out ADDR_W, meaning port B (read, 1-cycle latency).
REQ-015 SHALL have bank_full out 2 (per-bank loaded flag) and err out 1 (one-cycle illegal-command pulse).

Function
REQ-016 SHALL keep registers wb (write bank) and rb (read bank), both independent toggles.
REQ-017 Load FSM SHALL have states L_IDLE, L_FILL and L_DONE.
- L_IDLE to L_FILL on ld_start when bank_full[wb]==0 and ld_len is legal; latch ld_len; clear wr_cnt.
REQ-018 In L_FILL, ld_ready SHALL equal 1.
- On ld_valid&ld_ready: bram_a_en=bram_a_wen=1, bram_a_addr={wb,wr_cnt}, bram_a_din=ld_data, all combinational in the same cycle; wr_cnt increments.
REQ-019 Accepting row ld_len-1 SHALL move to L_DONE.
- L_DONE lasts one cycle: set bank_full[wb]=1, toggle wb, return to L_IDLE.
REQ-020 Read FSM SHALL have states R_IDLE, R_READ and R_DRAIN.
- R_IDLE to R_READ on rd_start when bank_full[rb]==1 and rd_len is legal; latch rd_len and rd_free; clear rd_cnt.
REQ-021 In R_READ, rd_next SHALL drive bram_b_en=1 and bram_b_addr={rb,rd_cnt}, and rd_cnt increments.
- rd_valid asserts exactly 1 cycle later.
- No backpressure on returned data.
REQ-022 Issuing row rd_len-1 SHALL move to R_DRAIN.
- Next cycle: rd_valid for last row, rd_done=1.
- If latched rd_free==1, clear bank_full[rb] and toggle rb; otherwise keep both (same bank re-readable).
- Return to R_IDLE.
REQ-023 rd_next outside R_READ SHALL be ignored (no enable, no rd_valid).
REQ-024 err SHALL pulse for one cycle in each of these cases:
- ld_start while not L_IDLE;
- ld_start with bank_full[wb]==1;
- rd_start while not R_IDLE;
- rd_start with bank_full[rb]==0;
- illegal len.
Each such command SHALL otherwise be ignored.
REQ-025 Load and read SHALL run concurrently on opposite banks.
- Loader cannot write a full bank; reader reads only full banks.
- Port A and port B therefore never address the same bank row during a write.
REQ-026 When L_DONE sets and R_DRAIN clears in the same cycle, each SHALL apply to its own bank bit; both updates take effect.
REQ-027 ld_start and rd_start in the same cycle SHALL both be accepted if individually legal.

Reset
REQ-028 On rst SHALL set FSMs to *_IDLE, and wb, rb, wr_cnt, rd_cnt, bank_full, err, rd_valid and rd_done to 0.
REQ-029 rst mid-operation SHALL abort both passes next cycle; all enables 0; partial bank contents discarded (bank_full=0).

Verification
REQ-030 ld_start, ld_len=3, rows 1,2,3 back-to-back -> port A writes addr 0x000..0x002, then bank_full=01 and wb=1.
REQ-031 After REQ-030: rd_start, rd_len=3, rd_free=1, rd_next each cycle -> bram_b_addr 0x000..0x002, rd_valid 3 cycles lagging by 1, rd_done on the 3rd, bank_full=00, rb=1.
REQ-032 Two loads of 4 rows, then third ld_start -> second writes 0x800..0x803, third gives err=1, bank_full=11.
REQ-033 Read pass with rd_free=0 -> bank_full unchanged; second rd_start re-reads 0x000 onward.
REQ-034 rd_start at reset, ld_len=0, and ld_start mid-fill -> each err pulse, state unchanged.
REQ-035 Concurrent load of bank 1 and read of bank 0, finishing in the same cycle; then rst asserted mid-load -> bank_full=10 after both finish; all outputs 0 and bank_full=00 after rst.
